// File: rtl/dmem_arb_pkg.sv
// Shared types, access-size encodings and the access legality check
// for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access size, taken from funct3[1:0].
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // High when the access must not reach the RAM: unknown size, a store
  // with an "unsigned" funct3, or a halfword/word access that is misaligned.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] func3,
                                      input logic [1:0] addr_lo);
    logic size_err;
    logic kind_err;
    case (func3[1:0])
      SZ_B:    size_err = 1'b0;
      SZ_H:    size_err = addr_lo[0];
      SZ_W:    size_err = (addr_lo != 2'b00);
      default: size_err = 1'b1;
    endcase
    kind_err = we & func3[2];
    return size_err | kind_err;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On a tie the requester that did not
// win the last accepted grant wins; last_grant only moves on advance.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       gnt_valid
);

  logic r_last_grant;

  // Pick the winner from the current requests and the last grant.
  always_comb begin
    gnt_valid = |req;
    grant     = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~r_last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Remember who won the last accepted request; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (advance) begin
      r_last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-cycle core's data
// memory. Requests are accepted in IDLE or RESP, the memory is driven
// for one ACCESS cycle, and the result is presented as a one-cycle
// response pulse on the port that issued the request.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              rst,

  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_we,
  input  logic [2:0]        rq0_func3,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rs0_valid,
  output logic [DATA_W-1:0] rs0_rdata,
  output logic              rs0_err,

  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_we,
  input  logic [2:0]        rq1_func3,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rs1_valid,
  output logic [DATA_W-1:0] rs1_rdata,
  output logic              rs1_err,

  output logic              mem_wr,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_grant;
  logic                w_gnt_valid;
  logic                w_can_accept;
  logic                w_accept;

  logic                w_sel_we;
  logic [2:0]          w_sel_func3;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_err;

  // Holding registers for the accepted request.
  logic                r_we;
  logic [2:0]          r_func3;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_id;
  logic                r_err;

  // Response registers, loaded at the end of ACCESS.
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rerr;

  logic                w_in_access;
  logic                w_in_resp;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({rq1_valid, rq0_valid}),
    .advance   (w_accept),
    .grant     (w_grant),
    .gnt_valid (w_gnt_valid)
  );

  assign w_in_access = (r_state == ACCESS);
  assign w_in_resp   = (r_state == RESP);

  // Handshake: only the granted requester sees ready, never during reset.
  always_comb begin
    w_can_accept = ((r_state == IDLE) || w_in_resp) && !rst && w_gnt_valid;
    rq0_ready    = w_can_accept && rq0_valid && (w_grant == 1'b0);
    rq1_ready    = w_can_accept && rq1_valid && (w_grant == 1'b1);
    w_accept     = rq0_ready || rq1_ready;
  end

  // Route the granted requester's payload and classify it.
  always_comb begin
    w_sel_we    = rq0_we;
    w_sel_func3 = rq0_func3;
    w_sel_addr  = rq0_addr;
    w_sel_wdata = rq0_wdata;
    if (w_grant) begin
      w_sel_we    = rq1_we;
      w_sel_func3 = rq1_func3;
      w_sel_addr  = rq1_addr;
      w_sel_wdata = rq1_wdata;
    end
    w_sel_err = access_err(w_sel_we, w_sel_func3, w_sel_addr[1:0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: ACCESS always lasts one cycle; RESP can chain straight
  // into the next ACCESS when a request is accepted alongside the response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? ACCESS : IDLE;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = w_accept ? ACCESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= w_sel_we;
      r_func3 <= w_sel_func3;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_id    <= w_grant;
      r_err   <= w_sel_err;
    end
  end

  // Sample the memory's combinational read data at the end of ACCESS;
  // stores and rejected accesses report zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else if (w_in_access) begin
      r_rdata <= (r_we || r_err) ? '0 : mem_rdata;
      r_rerr  <= r_err;
    end
  end

  // Memory side: address/data/size always reflect the holding registers,
  // the write strobe only fires in a legal store's ACCESS cycle.
  always_comb begin
    mem_wr    = w_in_access && r_we && !r_err && !rst;
    mem_func3 = r_func3;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
  end

  // Response side: pulse on the originating port only, other port idle.
  always_comb begin
    rs0_valid = w_in_resp && (r_id == 1'b0);
    rs1_valid = w_in_resp && (r_id == 1'b1);
    rs0_rdata = rs0_valid ? r_rdata : '0;
    rs1_rdata = rs1_valid ? r_rdata : '0;
    rs0_err   = rs0_valid && r_rerr;
    rs1_err   = rs1_valid && r_rerr;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a behavioural data memory, a queue-driven
// request driver and an independent response monitor with a scoreboard.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        rq0_valid, rq0_ready, rq0_we;
  logic [2:0]  rq0_func3;
  logic [31:0] rq0_addr, rq0_wdata;
  logic        rs0_valid, rs0_err;
  logic [31:0] rs0_rdata;
  logic        rq1_valid, rq1_ready, rq1_we;
  logic [2:0]  rq1_func3;
  logic [31:0] rq1_addr, rq1_wdata;
  logic        rs1_valid, rs1_err;
  logic [31:0] rs1_rdata;
  logic        mem_wr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  int   grant_log[$];
  int   acc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_seen = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rq0_valid (rq0_valid),
    .rq0_ready (rq0_ready),
    .rq0_we    (rq0_we),
    .rq0_func3 (rq0_func3),
    .rq0_addr  (rq0_addr),
    .rq0_wdata (rq0_wdata),
    .rs0_valid (rs0_valid),
    .rs0_rdata (rs0_rdata),
    .rs0_err   (rs0_err),
    .rq1_valid (rq1_valid),
    .rq1_ready (rq1_ready),
    .rq1_we    (rq1_we),
    .rq1_func3 (rq1_func3),
    .rq1_addr  (rq1_addr),
    .rq1_wdata (rq1_wdata),
    .rs1_valid (rs1_valid),
    .rs1_rdata (rs1_rdata),
    .rs1_err   (rs1_err),
    .mem_wr    (mem_wr),
    .mem_func3 (mem_func3),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory: 256 bytes, little-endian, synchronous write,
  // combinational sign/zero-extending read.
  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic [31:0] rd_word;
  assign ma = mem_addr[7:0];

  always @(posedge clk) begin
    if (mem_wr) begin
      case (mem_func3[1:0])
        2'b00: mem[ma] <= mem_wdata[7:0];
        2'b01: begin
          mem[ma]        <= mem_wdata[7:0];
          mem[ma + 8'd1] <= mem_wdata[15:8];
        end
        default: begin
          mem[ma]        <= mem_wdata[7:0];
          mem[ma + 8'd1] <= mem_wdata[15:8];
          mem[ma + 8'd2] <= mem_wdata[23:16];
          mem[ma + 8'd3] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  always_comb begin
    rd_word = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    case (mem_func3)
      3'b000:  mem_rdata = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  mem_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  mem_rdata = {24'd0, rd_word[7:0]};
      3'b101:  mem_rdata = {16'd0, rd_word[15:0]};
      default: mem_rdata = rd_word;
    endcase
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic req_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    req_t r;
    r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    r.exp_rdata = exp_rdata; r.exp_err = exp_err;
    return r;
  endfunction

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rs0_valid || rs1_valid) begin
        chk("rsp_pending", 64'(sb.size() > 0), 64'(1));
        chk("rsp_one_port", 64'(rs0_valid & rs1_valid), 64'(0));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_port", 64'(rs1_valid ? 1 : 0), 64'(e.port));
          chk("rsp_rdata", 64'(rs1_valid ? rs1_rdata : rs0_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rs1_valid ? rs1_err : rs0_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(2));
          chk("rsp_other_quiet", rs1_valid ? 64'({rs0_rdata, rs0_err}) : 64'({rs1_rdata, rs1_err}), 64'(0));
        end
      end
      if (rq0_ready || rq1_ready) chk("ready_excl", 64'(rq0_ready & rq1_ready), 64'(0));
      if (mem_wr) begin
        chk("mem_addr_hi", 64'(mem_addr[31:8]), 64'(0));
        wr_seen++;
      end
    end
  end

  // Present queued requests until all are accepted, then wait for responses.
  task automatic run(input int budget);
    int   n;
    exp_t x;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      rq0_valid = (q0.size() != 0);
      if (q0.size() != 0) begin
        rq0_we = q0[0].we; rq0_func3 = q0[0].f3; rq0_addr = q0[0].addr; rq0_wdata = q0[0].wdata;
      end
      rq1_valid = (q1.size() != 0);
      if (q1.size() != 0) begin
        rq1_we = q1[0].we; rq1_func3 = q1[0].f3; rq1_addr = q1[0].addr; rq1_wdata = q1[0].wdata;
      end
      @(negedge clk);
      if (rq0_valid && rq0_ready) begin
        x.port = 0; x.rdata = q0[0].exp_rdata; x.err = q0[0].exp_err; x.acc_cyc = cyc;
        sb.push_back(x); grant_log.push_back(0); acc_log.push_back(cyc);
        void'(q0.pop_front());
      end
      if (rq1_valid && rq1_ready) begin
        x.port = 1; x.rdata = q1[0].exp_rdata; x.err = q1[0].exp_err; x.acc_cyc = cyc;
        sb.push_back(x); grant_log.push_back(1); acc_log.push_back(cyc);
        void'(q1.pop_front());
      end
      n++;
    end
    chk("accept_timeout", 64'(q0.size() + q1.size()), 64'(0));
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 8) begin
      @(posedge clk);
      n++;
    end
    chk("rsp_timeout", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({rq0_ready, rq1_ready, rs0_valid, rs0_err, rs1_valid, rs1_err, mem_wr, mem_func3}), 64'(0));
    chk({tag, "_rdata"}, {rs0_rdata, rs1_rdata}, 64'(0));
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rq0_valid = 1'b0; rq1_valid = 1'b0;
    @(negedge clk);
    chk("rst_gated", 64'({rq0_ready, rq1_ready, mem_wr}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("post_rst");
  endtask

  initial begin
    int w0;
    int n;
    rst = 1'b1;
    rq0_valid = 1'b0; rq0_we = 1'b0; rq0_func3 = '0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_func3 = '0; rq1_addr = '0; rq1_wdata = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Preload through requester 1 (stores respond with zero data).
    q1.push_back(mk(1'b1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 1'b0));
    q1.push_back(mk(1'b1, 3'b010, 32'h40, 32'h1234_5678, 32'h0, 1'b0));
    q1.push_back(mk(1'b1, 3'b010, 32'h30, 32'h1122_3344, 32'h0, 1'b0));
    run(20);

    // Byte/half selection with sign and zero extension.
    q0.push_back(mk(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0));
    q0.push_back(mk(1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00F0, 1'b0));
    q0.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0));
    q0.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0));
    q0.push_back(mk(1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_00F0, 1'b0));
    run(20);

    // Store halfword then load the whole word.
    q1.push_back(mk(1'b1, 3'b001, 32'h42, 32'h0000_BEEF, 32'h0, 1'b0));
    q1.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hBEEF_5678, 1'b0));
    run(20);

    // Tie fairness from reset: both requesters valid back to back.
    do_reset();
    grant_log.delete(); acc_log.delete();
    q0.push_back(mk(1'b1, 3'b010, 32'h20, 32'hA0A0_0001, 32'h0, 1'b0));
    q0.push_back(mk(1'b1, 3'b010, 32'h20, 32'hA0A0_0002, 32'h0, 1'b0));
    q1.push_back(mk(1'b1, 3'b010, 32'h24, 32'hB0B0_0001, 32'h0, 1'b0));
    q1.push_back(mk(1'b1, 3'b010, 32'h24, 32'hB0B0_0002, 32'h0, 1'b0));
    run(30);
    chk("tie_count", 64'(grant_log.size()), 64'(4));
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("tie_grant", 64'(grant_log[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk("tie_spacing", 64'(acc_log[i] - acc_log[i-1]), 64'(2));
    end
    q0.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'hA0A0_0002, 1'b0));
    q1.push_back(mk(1'b0, 3'b010, 32'h24, 32'h0, 32'hB0B0_0002, 1'b0));
    run(20);

    // Rejected accesses: error flag, zero data, no write strobe.
    w0 = wr_seen;
    q0.push_back(mk(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1));
    q0.push_back(mk(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1));
    q0.push_back(mk(1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF, 32'h0, 1'b1));
    q1.push_back(mk(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1));
    q1.push_back(mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1));
    q1.push_back(mk(1'b0, 3'b101, 32'h41, 32'h0, 32'h0, 1'b1));
    run(30);
    chk("err_no_write", 64'(wr_seen - w0), 64'(0));
    q0.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 1'b0));
    run(20);

    // Reset during the ACCESS cycle of a store.
    @(posedge clk); #1;
    rq0_valid = 1'b1; rq0_we = 1'b1; rq0_func3 = 3'b010; rq0_addr = 32'h30; rq0_wdata = 32'hDEAD_BEEF;
    n = 0;
    @(negedge clk);
    while (!rq0_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("rstw_accept", 64'(rq0_ready), 64'(1));
    @(posedge clk); #1;
    rq0_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstw_mem_wr", 64'(mem_wr), 64'(0));
    chk("rstw_mem_addr", 64'(mem_addr), 64'(32'h30));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("rstw_after");
    q0.push_back(mk(1'b0, 3'b010, 32'h30, 32'h0, 32'h1122_3344, 1'b0));
    run(20);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-cycle core's data memory. Shares the one `data_mem` instance between requester 0 (core load/store unit) and requester 1 (debug/DMA loader port). It does this with round-robin grant, a valid/ready request handshake and a one-cycle response pulse. It also rejects misaligned or illegal accesses before they reach the RAM. It drives the memory's `memwr_sgn`/`func3`/`alu_result`/`rd_data2` inputs and samples its combinational `read_data`.

## Interface
Parameters:
- `ADDR_W`, default 32, byte-address width
- `DATA_W`, default 32, data width; only 32 supported

Ports (i = 0, 1; one set per requester):
- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `rq{i}_valid`  in  1  request present
- `rq{i}_ready`  out  1  request accepted this cycle when high with valid
- `rq{i}_we`  in  1  1 = store, 0 = load
- `rq{i}_func3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `rq{i}_addr`  in  ADDR_W  byte address
- `rq{i}_wdata`  in  DATA_W  store data, right-aligned
- `rs{i}_valid`  out  1  one-cycle response pulse; no backpressure
- `rs{i}_rdata`  out  DATA_W  load result, already extended by memory; 0 for stores and errors
- `rs{i}_err`  out  1  access rejected (valid only with `rs{i}_valid`)
- `mem_wr`  out  1  to memory `memwr_sgn`
- `mem_func3`  out  3  to memory `func3`
- `mem_addr`  out  ADDR_W  to memory `alu_result`
- `mem_wdata`  out  DATA_W  to memory `rd_data2`
- `mem_rdata`  in  DATA_W  from memory `read_data` (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE→ACCESS and RESP→ACCESS on an accepted request. RESP→IDLE if none. ACCESS→RESP always.
- Acceptance is possible in IDLE and RESP only. `rq{i}_ready` is combinational: state∈{IDLE,RESP} & rq{i}_valid & grant==i. At most one ready is high per cycle.
- Arbitration: a single valid requester wins. If both are valid, the winner is the requester ≠ `last_grant`. `last_grant` updates on every acceptance. Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- On acceptance, latch we, func3, addr, wdata, grant id and err into holding registers.
- err=1 when any of the following holds:
  - func3[1:0]=11
  - we & func3[2]
  - func3[1:0]=01 & addr[0]
  - func3[1]=1 & addr[1:0]≠0
- ACCESS:
  - `mem_func3`/`mem_addr`/`mem_wdata` come from the holding registers.
  - `mem_wr` = we_q & ~err_q & ~rst.
  - For a load, `mem_rdata` is captured into the response register at the closing edge. Stores and errors capture 0.
- RESP: `rs{id_q}_valid`=1, with `rs{id_q}_rdata` and `rs{id_q}_err` from the registers. The other response port stays 0.
- Outside ACCESS: `mem_wr`=0, and the other mem_* outputs hold their last registered values.

## Timing
- Request accepted at edge N. Memory accessed in cycle N+1, with the write committed at edge N+1. Response valid in cycle N+2.
- Throughput: back-to-back acceptances every 2 cycles (accept in RESP).
- Load data is the memory contents before any write committed in the same ACCESS cycle. Only one access per cycle, so no same-cycle hazard arises.
- A store followed by a load to the same word returns the new data.
- Reset:
  - state=IDLE, `last_grant`=1, all holding/response registers 0.
  - All outputs are 0: readies, `rs*_valid`, `rs*_rdata`, `rs*_err`, `mem_wr`, `mem_func3`, `mem_addr`, `mem_wdata`.
- `rst` asserted during ACCESS: `mem_wr` forced 0 that cycle, so no write is committed, and the pending response is dropped.
- `rst` asserted during RESP: the response is still visible that cycle, and no new request is accepted (ready gated by ~rst).
- A requester dropping valid without ready: no effect. Requesters must hold valid and payload until ready.

## Structure
- Package `dmem_arb_pkg`:
  - state enum {IDLE, ACCESS, RESP}
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - function `access_err(we, func3, addr[1:0])`
- One sub-module `rr_arb2`: two-request round-robin with `last_grant` register, inputs req[1:0]/advance, output grant index and gnt_valid. FSM and datapath stay in `dmem_arbiter`.

## Test plan
- Single load, byte select: preload word 0x8000_00F0 at address 0x10. rq0 LB addr 0x10 → `rs0_valid` 2 cycles after accept, `rdata`=0xFFFF_FFF0, err=0. Repeat with LBU → 0x0000_00F0.
- Tie fairness: both valid continuously with SW to 0x20 and 0x24. Grants alternate 0,1,0,1 from reset, with acceptances every 2 cycles.
- Store-then-load: rq1 SH 0xBEEF to 0x42, then LW 0x40 → upper half 0xBEEF, lower half unchanged.
- Errors: each rejected access returns `rs_err`=1, `rdata`=0, and `mem_wr` never asserts.
  - LW at 0x02
  - SH at 0x03
  - store with func3=3'b100
  - func3=3'b011
- Reset mid-write: assert `rst` in the ACCESS cycle of SW 0xDEAD_BEEF to 0x30. Memory word unchanged, no `rs*_valid`, all outputs 0 the next cycle.
